// File: rtl/alu_pad_exerciser_if.sv
// Wishbone slave bus used to configure and launch the ALU pad exerciser.
interface alu_pad_exerciser_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/alu_pad_exerciser.sv
// Drives LFSR vectors onto the dual-ALU pad bus, samples the results after a
// programmable settle time and accumulates consistency errors.
module alu_pad_exerciser #(
  parameter logic [3:0]  SETTLE_RST = 4'd4,
  parameter logic [19:0] SEED_RST   = 20'h00001
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  alu_pad_exerciser_if.slave  wbs,
  output logic [3:0]          ex_a0,
  output logic [3:0]          ex_b0,
  output logic [3:0]          ex_a1,
  output logic [3:0]          ex_b1,
  output logic [1:0]          ex_sel1,
  output logic [1:0]          ex_sel2,
  input  logic [3:0]          res_out1,
  input  logic [3:0]          res_out2,
  input  logic                res_carry1,
  input  logic                res_carry2,
  input  logic [3:0]          res_x,
  input  logic                res_y,
  output logic                busy,
  output logic                irq
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [19:0] lfsr_step(input logic [19:0] v);
    return {v[18:0], v[19] ^ v[16]};
  endfunction

  // Packed as {sel2, sel1, b1, a1, b0, a0}; mirror copies lane 0 onto lane 1.
  function automatic logic [19:0] map_vec(input logic [19:0] v, input logic mirror);
    if (mirror) begin
      return {v[17:16], v[17:16], v[7:4], v[3:0], v[7:4], v[3:0]};
    end else begin
      return v;
    end
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_mirror, r_irq_en;
  logic [19:0] r_seed;
  logic [15:0] r_count;
  logic [3:0]  r_settle;
  logic        r_done, r_fail, r_aborted;
  logic [15:0] r_completed, r_errcnt;
  logic [19:0] r_first_err;
  logic [15:0] r_n;
  logic [3:0]  r_s, r_set_cnt;
  logic        r_run_mirror;
  logic [19:0] r_lfsr, r_ex;
  logic        r_busy, r_irq;

  logic        w_req, w_wr;
  logic        w_wr_ctrl, w_wr_seed, w_wr_count, w_wr_settle, w_wr_status;
  logic        w_start, w_abort, w_check, w_mismatch;
  logic        w_in_settle, w_in_sample, w_in_done;
  logic [15:0] w_completed_inc;
  logic [19:0] w_lfsr_nxt;
  logic        w_mirror_nxt, w_done_nxt, w_irq_en_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_req       = wbs.wbs_stb_i & wbs.wbs_cyc_i;
  assign w_wr        = r_ack & w_req & wbs.wbs_we_i;
  assign w_wr_ctrl   = w_wr & (wbs.wbs_adr_i[4:2] == 3'd0);
  assign w_wr_seed   = w_wr & (wbs.wbs_adr_i[4:2] == 3'd1);
  assign w_wr_count  = w_wr & (wbs.wbs_adr_i[4:2] == 3'd2);
  assign w_wr_settle = w_wr & (wbs.wbs_adr_i[4:2] == 3'd3);
  assign w_wr_status = w_wr & (wbs.wbs_adr_i[4:2] == 3'd4);
  assign w_unused    = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:5], wbs.wbs_adr_i[1:0],
                         wbs.wbs_dat_i[31:20]};

  // Abort beats a simultaneous start; both only act in the appropriate state.
  assign w_start = w_wr_ctrl & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[3] & (r_state == ST_IDLE);
  assign w_abort = w_wr_ctrl & wbs.wbs_dat_i[3] & (r_state != ST_IDLE);
  assign w_check = w_in_sample & ~w_abort;
  assign w_completed_inc = r_completed + 16'd1;

  assign w_mismatch = (res_x != (res_out1 ^ res_out2)) |
                      (res_y != (res_carry1 ^ res_carry2)) |
                      (r_run_mirror & ((res_out1 != res_out2) | (res_carry1 != res_carry2)));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = (r_count == 16'd0) ? ST_DONE : ST_DRIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (r_set_cnt == (r_s - 4'd1)) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (w_completed_inc < r_n) begin
          w_state_nxt = ST_DRIVE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  always_comb begin
    w_in_settle = 1'b0;
    w_in_sample = 1'b0;
    w_in_done   = 1'b0;
    case (r_state)
      ST_SETTLE: w_in_settle = 1'b1;
      ST_SAMPLE: w_in_sample = 1'b1;
      ST_DONE:   w_in_done   = 1'b1;
      default:   w_in_done   = 1'b0;
    endcase
  end

  always_comb begin
    w_lfsr_nxt   = r_lfsr;
    w_mirror_nxt = r_run_mirror;
    w_irq_en_nxt = r_irq_en;
    w_done_nxt   = r_done;
    if (w_start) begin
      w_lfsr_nxt   = r_seed;
      w_mirror_nxt = wbs.wbs_dat_i[1];
    end else if (w_check) begin
      w_lfsr_nxt   = lfsr_step(r_lfsr);
    end else begin
      w_lfsr_nxt   = r_lfsr;
    end
    if (w_wr_ctrl) begin
      w_irq_en_nxt = wbs.wbs_dat_i[2];
    end else begin
      w_irq_en_nxt = r_irq_en;
    end
    // Setting done wins over a same-cycle W1C clear.
    if (w_start) begin
      w_done_nxt = 1'b0;
    end else if (w_in_done | w_abort) begin
      w_done_nxt = 1'b1;
    end else if (w_wr_status & wbs.wbs_dat_i[1]) begin
      w_done_nxt = 1'b0;
    end else begin
      w_done_nxt = r_done;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (wbs.wbs_adr_i[4:2])
      3'd0:    w_rdata = {29'd0, r_irq_en, r_mirror, 1'b0};
      3'd1:    w_rdata = {12'd0, r_seed};
      3'd2:    w_rdata = {16'd0, r_count};
      3'd3:    w_rdata = {28'd0, r_settle};
      3'd4:    w_rdata = {r_completed, 12'd0, r_aborted, r_fail, r_done, r_busy};
      3'd5:    w_rdata = {16'd0, r_errcnt};
      3'd6:    w_rdata = {12'd0, r_first_err};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_req & ~r_ack;
      r_dat <= (w_req & ~r_ack & ~wbs.wbs_we_i) ? w_rdata : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mirror <= 1'b0;
      r_irq_en <= 1'b0;
      r_seed   <= SEED_RST;
      r_count  <= 16'd0;
      r_settle <= SETTLE_RST;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      if (w_wr_ctrl)   r_mirror <= wbs.wbs_dat_i[1];
      if (w_wr_seed)   r_seed   <= (wbs.wbs_dat_i[19:0] == 20'd0) ? 20'h00001 : wbs.wbs_dat_i[19:0];
      if (w_wr_count)  r_count  <= wbs.wbs_dat_i[15:0];
      if (w_wr_settle) r_settle <= wbs.wbs_dat_i[3:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_aborted   <= 1'b0;
      r_completed <= 16'd0;
      r_errcnt    <= 16'd0;
      r_first_err <= 20'd0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start) begin
        r_fail      <= 1'b0;
        r_aborted   <= 1'b0;
        r_completed <= 16'd0;
        r_errcnt    <= 16'd0;
        r_first_err <= 20'd0;
      end else begin
        if (w_abort) r_aborted <= 1'b1;
        if (w_check) begin
          r_completed <= w_completed_inc;
          if (w_mismatch) begin
            r_fail <= 1'b1;
            if (r_errcnt != 16'hFFFF) r_errcnt <= r_errcnt + 16'd1;
            if (r_errcnt == 16'd0) r_first_err <= r_lfsr;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_n          <= 16'd0;
      r_s          <= 4'd1;
      r_run_mirror <= 1'b0;
      r_lfsr       <= 20'h00001;
      r_set_cnt    <= 4'd0;
      r_ex         <= 20'd0;
      r_busy       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      if (w_start) begin
        r_n <= r_count;
        r_s <= (r_settle == 4'd0) ? 4'd1 : r_settle;
      end
      r_run_mirror <= w_mirror_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_set_cnt    <= w_in_settle ? (r_set_cnt + 4'd1) : 4'd0;
      // ex_* only change when entering DRIVE, so they hold through the run and after it.
      if (w_state_nxt == ST_DRIVE && r_state != ST_DRIVE) r_ex <= map_vec(w_lfsr_nxt, w_mirror_nxt);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_irq        <= w_done_nxt & w_irq_en_nxt;
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign ex_a0   = r_ex[3:0];
  assign ex_b0   = r_ex[7:4];
  assign ex_a1   = r_ex[11:8];
  assign ex_b1   = r_ex[15:12];
  assign ex_sel1 = r_ex[17:16];
  assign ex_sel2 = r_ex[19:18];
  assign busy    = r_busy;
  assign irq     = r_irq;

endmodule

// File: tb/tb_alu_pad_exerciser.sv
// Randomized bench for alu_pad_exerciser: an ALU pad stub answers the driven
// vectors and a run-level model predicts vectors, timing and error status.
module tb_alu_pad_exerciser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pad_exerciser_if wbs();
  logic [3:0] ex_a0, ex_b0, ex_a1, ex_b1, res_out1, res_out2, res_x;
  logic [1:0] ex_sel1, ex_sel2;
  logic       res_carry1, res_carry2, res_y, busy, irq;

  int stub_kind  = 0;
  int stub_fault = 0;
  logic [14:0] stub_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cycle = 0;
  logic [19:0] m_vec[$];
  logic [19:0] cap[$];
  int          m_errs;
  logic [19:0] m_first;

  alu_pad_exerciser #(.SETTLE_RST(4'd4), .SEED_RST(20'h00001)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs),
    .ex_a0(ex_a0), .ex_b0(ex_b0), .ex_a1(ex_a1), .ex_b1(ex_b1),
    .ex_sel1(ex_sel1), .ex_sel2(ex_sel2),
    .res_out1(res_out1), .res_out2(res_out2),
    .res_carry1(res_carry1), .res_carry2(res_carry2),
    .res_x(res_x), .res_y(res_y), .busy(busy), .irq(irq)
  );

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] alu4(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Pad stub: kind 0 = loopback, 1 = small ALU; faults 1 force y, 2 corrupt x, 3 break lane symmetry.
  function automatic logic [14:0] stub_resp(input logic [19:0] v, input int kind, input int fault);
    logic [3:0] o1, o2, x;
    logic c1, c2, y;
    if (kind == 0) begin
      o1 = v[3:0]; o2 = v[11:8]; c1 = 1'b0; c2 = 1'b0;
    end else begin
      {c1, o1} = alu4(v[3:0], v[7:4], v[17:16]);
      {c2, o2} = alu4(v[11:8], v[15:12], v[19:18]);
    end
    if (fault == 3 && v[1]) o2 = o2 ^ 4'h8;
    x = o1 ^ o2;
    y = c1 ^ c2;
    if (fault == 1) y = 1'b1;
    if (fault == 2 && v[0]) x = x ^ 4'h1;
    return {o1, o2, c1, c2, x, y};
  endfunction

  assign stub_bus = stub_resp({ex_sel2, ex_sel1, ex_b1, ex_a1, ex_b0, ex_a0}, stub_kind, stub_fault);
  assign res_out1   = stub_bus[14:11];
  assign res_out2   = stub_bus[10:7];
  assign res_carry1 = stub_bus[6];
  assign res_carry2 = stub_bus[5];
  assign res_x      = stub_bus[4:1];
  assign res_y      = stub_bus[0];

  // Reference: walk the run vector by vector and apply the consistency rules.
  task automatic model_run(input logic [19:0] seed, input int n, input bit mirror);
    logic [19:0] v, mv;
    logic [14:0] r;
    bit bad;
    v = seed;
    m_vec.delete();
    m_errs = 0;
    m_first = 20'd0;
    for (int i = 0; i < n; i++) begin
      mv = v;
      if (mirror) begin
        mv[11:8] = v[3:0]; mv[15:12] = v[7:4]; mv[19:18] = v[17:16];
      end
      m_vec.push_back(mv);
      r = stub_resp(mv, stub_kind, stub_fault);
      bad = (r[4:1] != (r[14:11] ^ r[10:7])) || (r[0] != (r[6] ^ r[5]));
      if (mirror && ((r[14:11] != r[10:7]) || (r[6] != r[5]))) bad = 1'b1;
      if (bad) begin
        if (m_errs == 0) m_first = v;
        m_errs++;
      end
      v = ((v << 1) & 20'hFFFFF) | (((v >> 19) ^ (v >> 16)) & 20'h1);
    end
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n = 0;
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1; wbs.wbs_we_i = we;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = adr; wbs.wbs_dat_i = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs.wbs_ack_o && n < 16);
    chk_eq("ack_latency", n, 1);
    rd = wbs.wbs_dat_o;
    @(negedge clk);
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    chk_eq("ack_width", {31'd0, wbs.wbs_ack_o}, 0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'd0, rd);
  endtask

  task automatic wait_idle(input int unsigned t0, input int n, input int per, input bit cap_en);
    while (busy && (cycle - t0) < 5000) begin
      if (cap_en && ((cycle - t0) % per) == 0 && cap.size() < n)
        cap.push_back({ex_sel2, ex_sel1, ex_b1, ex_a1, ex_b0, ex_a0});
      @(negedge clk);
    end
  endtask

  task automatic do_run(input string tag, input logic [19:0] seed_w, input int n, input int s,
                        input bit mirror, input bit irq_en, input int kind, input int fault);
    logic [31:0] rd;
    int unsigned t0;
    int per;
    stub_kind = kind;
    stub_fault = fault;
    wb_write(32'h04, {12'd0, seed_w});
    wb_write(32'h08, n);
    wb_write(32'h0C, s);
    model_run((seed_w == 20'd0) ? 20'h00001 : seed_w, n, mirror);
    per = ((s == 0) ? 1 : s) + 2;
    cap.delete();
    wb_write(32'h00, {29'd0, irq_en, mirror, 1'b1});
    t0 = cycle;
    chk_eq({tag, "_busy_rise"}, {31'd0, busy}, 1);
    wait_idle(t0, n, per, 1'b1);
    chk_eq({tag, "_busy_len"}, cycle - t0, n * per + 1);
    chk_eq({tag, "_irq"}, {31'd0, irq}, {31'd0, irq_en});
    for (int i = 0; i < n; i++)
      chk_eq($sformatf("%s_vec%0d", tag, i), (i < cap.size()) ? cap[i] : 20'hxxxxx, m_vec[i]);
    if (n > 0)
      chk_eq({tag, "_ex_hold"}, {ex_sel2, ex_sel1, ex_b1, ex_a1, ex_b0, ex_a0}, m_vec[n-1]);
    wb_read(32'h10, rd);
    chk_eq({tag, "_status"}, rd, (n << 16) | ((m_errs > 0) ? 32'h4 : 32'h0) | 32'h2);
    wb_read(32'h14, rd);
    chk_eq({tag, "_errcnt"}, rd, m_errs);
    wb_read(32'h18, rd);
    chk_eq({tag, "_first_err"}, rd, {12'd0, m_first});
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rst_exp[8];
    int unsigned t0;
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'h0; wbs.wbs_adr_i = 32'd0; wbs.wbs_dat_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk_eq("rst_busy", {31'd0, busy}, 0);
    chk_eq("rst_irq", {31'd0, irq}, 0);
    chk_eq("rst_ack", {31'd0, wbs.wbs_ack_o}, 0);
    chk_eq("rst_ex", {ex_sel2, ex_sel1, ex_b1, ex_a1, ex_b0, ex_a0}, 0);
    rst_exp = '{32'd0, 32'd1, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      wb_read(i * 4, rd);
      chk_eq($sformatf("rst_reg%0d", i), rd, rst_exp[i]);
    end

    // Loopback, mirror, seed 1, N=8, S=4.
    do_run("mirror", 20'h00001, 8, 4, 1'b1, 1'b0, 0, 0);
    chk_eq("mirror_first", cap.size() > 0 ? cap[0] : 20'd0, 20'h00101);
    chk_eq("mirror_second", cap.size() > 1 ? cap[1] : 20'd0, 20'h00202);

    do_run("nomirror", 20'h00001, 8, 4, 1'b0, 1'b0, 0, 0);
    do_run("force_y", 20'h00001, 5, 4, 1'b0, 1'b0, 0, 1);
    wb_read(32'h14, rd);
    chk_eq("force_y_errcnt5", rd, 5);
    wb_read(32'h18, rd);
    chk_eq("force_y_first1", rd, 32'h1);

    do_run("n0", 20'h00001, 0, 4, 1'b0, 1'b0, 0, 0);

    // A start issued mid-run must not extend or restart it.
    stub_fault = 0;
    wb_write(32'h08, 3);
    wb_write(32'h0C, 2);
    wb_write(32'h00, 32'h1);
    t0 = cycle;
    repeat (3) @(negedge clk);
    wb_write(32'h00, 32'h1);
    wait_idle(t0, 0, 4, 1'b0);
    chk_eq("restart_busy_len", cycle - t0, 13);
    wb_read(32'h10, rd);
    chk_eq("restart_status", rd, (3 << 16) | 32'h2);

    // Abort inside the third vector of an N=100 run.
    wb_write(32'h04, 1);
    wb_write(32'h08, 100);
    wb_write(32'h0C, 4);
    wb_write(32'h00, 32'h1);
    t0 = cycle;
    while ((cycle - t0) < 14) @(negedge clk);
    wb_write(32'h00, 32'h8);
    chk_eq("abort_busy", {31'd0, busy}, 0);
    wb_read(32'h10, rd);
    chk_eq("abort_status", rd, (2 << 16) | 32'h8 | 32'h2);

    // irq follows done; W1C clears it.
    do_run("irq", 20'h00ABC, 3, 1, 1'b0, 1'b1, 1, 0);
    wb_write(32'h10, 32'h2);
    chk_eq("irq_w1c", {31'd0, irq}, 0);
    wb_read(32'h10, rd);
    chk_eq("w1c_status", rd & 32'h2, 0);
    wb_write(32'h04, 32'd0);
    wb_read(32'h04, rd);
    chk_eq("seed_zero", rd, 1);

    for (int it = 0; it < 10; it++) begin
      logic [19:0] sd;
      sd = ($urandom_range(0, 4) == 0) ? 20'd0 : 20'($urandom);
      do_run($sformatf("rnd%0d", it), sd, $urandom_range(1, 12), $urandom_range(0, 15),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 1), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
